// File: rtl/addsub_rr_scheduler_if.sv
// ----------------------------------------------------------------------------
// addsub_rr_scheduler_if
// Bundles the two requester handshakes and the response channel of the shared
// add/sub scheduler.
//   master : client side. Drives requests and rsp_ready, and observes readies and responses.
//   slave  : scheduler side. The mirror image of master.
// Signals:
//   reqN_valid/ready, reqN_x/y (WIDTH), reqN_sub     requester N, N = 0..1
//   rsp_valid/ready, rsp_id, rsp_result (WIDTH),
//   rsp_cout, rsp_overflow                            response channel
// ----------------------------------------------------------------------------
interface addsub_rr_scheduler_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_x;
    logic [WIDTH-1:0] req0_y;
    logic             req0_sub;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_x;
    logic [WIDTH-1:0] req1_y;
    logic             req1_sub;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_overflow;

    modport master (
        output req0_valid, req0_x, req0_y, req0_sub,
        output req1_valid, req1_x, req1_y, req1_sub,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_sub,
        input  req1_valid, req1_x, req1_y, req1_sub,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow,
        input  rsp_ready
    );
endinterface

// File: rtl/addsub_rr_scheduler.sv
// ----------------------------------------------------------------------------
// addsub_rr_scheduler
// Shares one WIDTH-bit two's-complement adder/subtractor between two
// requesters. Requests are granted round-robin. Each accepted operation runs
// once on the shared datapath. The result is returned with carry-out, signed
// overflow and the requester ID. Only one operation is in flight at a time.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave modport of addsub_rr_scheduler_if. It carries:
//          - the request channels, where reqN_ready is decoded combinationally;
//          - the response channel, whose outputs are all registered.
// ----------------------------------------------------------------------------
module addsub_rr_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    addsub_rr_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             last_grant_r;
    logic [WIDTH-1:0] op_x_r;
    logic [WIDTH-1:0] op_y_r;
    logic             op_sub_r;
    logic             op_id_r;

    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_cout_r;
    logic             rsp_overflow_r;

    logic             grant_s;
    logic             grant_id_s;
    logic [WIDTH+1:0] calc_s;

    // Returns {overflow, cout, result}. Subtraction is x + ~y + 1.
    function automatic logic [WIDTH+1:0] addsub_calc(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sub
    );
        logic [WIDTH-1:0] y_eff;
        logic [WIDTH:0]   sum;
        logic             ovf;
        y_eff = y ^ {WIDTH{sub}};
        sum   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
        ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        return {ovf, sum};
    endfunction

    // Arbitration: a grant happens only in IDLE. On a tie, the requester that was not served last wins.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
        if (!rst && (state_r == ST_IDLE)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_s    = 1'b1;
                grant_id_s = ~last_grant_r;
            end else if (bus.req0_valid) begin
                grant_s    = 1'b1;
                grant_id_s = 1'b0;
            end else if (bus.req1_valid) begin
                grant_s    = 1'b1;
                grant_id_s = 1'b1;
            end else begin
                grant_s    = 1'b0;
                grant_id_s = 1'b0;
            end
        end else begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
        end
    end

    // Ready decode, and the shared datapath working on the latched operands.
    always_comb begin
        bus.req0_ready = grant_s && !grant_id_s;
        bus.req1_ready = grant_s && grant_id_s;
        calc_s         = addsub_calc(op_x_r, op_y_r, op_sub_r);
    end

    // Control FSM, operand capture and the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            last_grant_r   <= 1'b1;
            op_x_r         <= {WIDTH{1'b0}};
            op_y_r         <= {WIDTH{1'b0}};
            op_sub_r       <= 1'b0;
            op_id_r        <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_id_r       <= 1'b0;
            rsp_result_r   <= {WIDTH{1'b0}};
            rsp_cout_r     <= 1'b0;
            rsp_overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        op_x_r   <= grant_id_s ? bus.req1_x   : bus.req0_x;
                        op_y_r   <= grant_id_s ? bus.req1_y   : bus.req0_y;
                        op_sub_r <= grant_id_s ? bus.req1_sub : bus.req0_sub;
                        op_id_r  <= grant_id_s;
                        state_r  <= ST_EXEC;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rsp_valid_r    <= 1'b1;
                    rsp_id_r       <= op_id_r;
                    rsp_result_r   <= calc_s[WIDTH-1:0];
                    rsp_cout_r     <= calc_s[WIDTH];
                    rsp_overflow_r <= calc_s[WIDTH+1];
                    state_r        <= ST_RESP;
                end
                ST_RESP: begin
                    // The response data stays in its registers after the handshake. Only valid drops.
                    if (bus.rsp_ready) begin
                        rsp_valid_r  <= 1'b0;
                        last_grant_r <= rsp_id_r;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r      <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_id       = rsp_id_r;
    assign bus.rsp_result   = rsp_result_r;
    assign bus.rsp_cout     = rsp_cout_r;
    assign bus.rsp_overflow = rsp_overflow_r;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_addsub_rr_scheduler
// Directed scenarios followed by a random sweep. A transaction-level model
// tracks the single in-flight operation and when its answer is due. The
// arithmetic is done with signed/unsigned integers. Directed literal checks
// pin the model.
// ----------------------------------------------------------------------------
module tb_addsub_rr_scheduler;
    localparam int W = 4;
    localparam int M = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    addsub_rr_scheduler_if #(.WIDTH(W)) bus ();
    addsub_rr_scheduler #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic, returning {ovf, cout, result[3:0]}.
    function automatic logic [5:0] ref_op(input int xu, input int yu, input bit sub);
        int xs, ys, s, res;
        bit ovf, cout;
        xs   = (xu >= M/2) ? xu - M : xu;
        ys   = (yu >= M/2) ? yu - M : yu;
        s    = sub ? xs - ys : xs + ys;
        ovf  = (s > M/2 - 1) || (s < -(M/2));
        res  = ((s % M) + M) % M;
        cout = sub ? (xu >= yu) : (xu + yu >= M);
        return {ovf, cout, res[3:0]};
    endfunction

    // ---------------- transaction model, checked every cycle ----------------
    int   cyc = 0;
    bit   started = 0;
    bit   pend_valid = 0;
    bit   pend_id = 0;
    logic [5:0] pend_calc = '0;
    int   pend_due = 0;
    bit   last_served = 1;
    bit   rsp_clear = 0;

    always @(negedge clk) begin
        bit exp_rv, g_ok, g_id;
        if (rst) started = 1;
        if (started) begin
            exp_rv = pend_valid && (cyc >= pend_due);
            g_ok = 0; g_id = 0;
            if (!rst && !pend_valid) begin
                if (bus.req0_valid && bus.req1_valid) begin g_ok = 1; g_id = !last_served; end
                else if (bus.req0_valid) begin g_ok = 1; g_id = 0; end
                else if (bus.req1_valid) begin g_ok = 1; g_id = 1; end
            end
            chk("m_ready0", bus.req0_ready, g_ok && !g_id);
            chk("m_ready1", bus.req1_ready, g_ok && g_id);
            chk("m_rsp_valid", bus.rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("m_rsp_id", bus.rsp_id, pend_id);
                chk("m_rsp_result", bus.rsp_result, pend_calc[3:0]);
                chk("m_rsp_cout", bus.rsp_cout, pend_calc[4]);
                chk("m_rsp_ovf", bus.rsp_overflow, pend_calc[5]);
            end else if (rsp_clear) begin
                chk("m_rsp_zero", {bus.rsp_id, bus.rsp_result, bus.rsp_cout, bus.rsp_overflow}, 0);
            end
            if (exp_rv) rsp_clear = 0;
            if (rst) begin
                pend_valid = 0; last_served = 1; rsp_clear = 1;
            end else if (exp_rv && bus.rsp_ready) begin
                pend_valid = 0; last_served = pend_id;
            end else if (g_ok) begin
                pend_valid = 1;
                pend_id    = g_id;
                pend_due   = cyc + 2;
                pend_calc  = g_id ? ref_op(int'(bus.req1_x), int'(bus.req1_y), bus.req1_sub)
                                  : ref_op(int'(bus.req0_x), int'(bus.req0_y), bus.req0_sub);
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string name, output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid === 1'b1) break;
        end
        if (bus.rsp_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_rsp required=rsp_within_10", name);
        end
    endtask

    task automatic drain();
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
        repeat (8) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g_cnt;
        int grants[4];
        logic [6:0] held;
        bit acc0, acc1;

        bus.req0_valid = 0; bus.req0_x = 0; bus.req0_y = 0; bus.req0_sub = 0;
        bus.req1_valid = 0; bus.req1_x = 0; bus.req1_y = 0; bus.req1_sub = 0;
        bus.rsp_ready  = 1;

        // Pin the model with the hand-computed cases.
        chk("pin_7p1", ref_op(7, 1, 0), 6'b10_1000);
        chk("pin_m8m1", ref_op(8, 1, 1), 6'b11_0111);
        chk("pin_3pm2", ref_op(3, 14, 0), 6'b01_0001);
        chk("pin_5m0", ref_op(5, 0, 1), 6'b01_0101);

        // Reset, then req0 only: 7 + 1.
        repeat (2) step();
        rst = 0;
        bus.req0_valid = 1; bus.req0_x = 4'd7; bus.req0_y = 4'd1; bus.req0_sub = 0;
        @(negedge clk);
        chk("t1_ready0", bus.req0_ready, 1);
        chk("t1_reset_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_cout, bus.rsp_overflow}, 0);
        step();
        bus.req0_valid = 0;
        wait_rsp("t1", n);
        chk("t1_latency", n, 2);
        chk("t1_result", bus.rsp_result, 4'b1000);
        chk("t1_ovf", bus.rsp_overflow, 1);
        chk("t1_cout", bus.rsp_cout, 0);
        chk("t1_id", bus.rsp_id, 0);
        step();

        // req1 only: -8 - 1.
        bus.req1_valid = 1; bus.req1_x = 4'b1000; bus.req1_y = 4'd1; bus.req1_sub = 1;
        @(negedge clk);
        chk("t2_ready1", bus.req1_ready, 1);
        step();
        bus.req1_valid = 0;
        wait_rsp("t2", n);
        chk("t2_result", bus.rsp_result, 4'b0111);
        chk("t2_cout", bus.rsp_cout, 1);
        chk("t2_ovf", bus.rsp_overflow, 1);
        chk("t2_id", bus.rsp_id, 1);
        step();

        // Both requesters valid continuously after reset.
        rst = 1;
        step();
        rst = 0;
        bus.req0_valid = 1; bus.req0_x = 4'd3; bus.req0_y = 4'b1110; bus.req0_sub = 0;
        bus.req1_valid = 1; bus.req1_x = 4'd5; bus.req1_y = 4'd0;    bus.req1_sub = 1;
        g_cnt = 0;
        for (int i = 0; i < 40 && g_cnt < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin grants[g_cnt] = 0; g_cnt++; end
            else if (bus.req1_ready) begin grants[g_cnt] = 1; g_cnt++; end
            if (bus.rsp_valid && bus.rsp_id == 1'b0)
                chk("t3_rsp0", {bus.rsp_result, bus.rsp_cout, bus.rsp_overflow}, {4'b0001, 1'b1, 1'b0});
            if (bus.rsp_valid && bus.rsp_id == 1'b1)
                chk("t3_rsp1", {bus.rsp_result, bus.rsp_cout, bus.rsp_overflow}, {4'b0101, 1'b1, 1'b0});
            step();
        end
        chk("t3_grant_count", g_cnt, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), grants[i], i % 2);

        // Backpressure: hold RESP for 5 cycles with both requesters valid.
        bus.rsp_ready = 0;
        wait_rsp("t4", n);
        held = {bus.rsp_id, bus.rsp_result, bus.rsp_cout, bus.rsp_overflow};
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("t4_valid_held", bus.rsp_valid, 1);
            chk("t4_rsp_stable", {bus.rsp_id, bus.rsp_result, bus.rsp_cout, bus.rsp_overflow}, held);
            chk("t4_readies_low", {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        step();
        bus.rsp_ready = 1;
        @(negedge clk);
        chk("t4_handshake", bus.rsp_valid, 1);
        step();
        @(negedge clk);
        chk("t4_back_idle_valid", bus.rsp_valid, 0);
        chk("t4_back_idle_grant", bus.req0_ready ^ bus.req1_ready, 1);
        drain();

        // Reset in EXEC discards the transaction, then req0 wins the tie.
        bus.req1_valid = 1; bus.req1_x = 4'd2; bus.req1_y = 4'd3; bus.req1_sub = 0;
        @(negedge clk);
        chk("t5_ready1", bus.req1_ready, 1);
        step();
        rst = 1;
        bus.req0_valid = 1; bus.req0_x = 4'd6; bus.req0_y = 4'd6; bus.req0_sub = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("t5_rsp_cleared", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_cout, bus.rsp_overflow}, 0);
        chk("t5_ready0", bus.req0_ready, 1);
        chk("t5_ready1_low", bus.req1_ready, 0);
        step();
        drain();

        // Random sweep.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            step();
            if (bus.req0_valid && !acc0) begin
                if ($urandom_range(0, 7) == 0) bus.req0_valid = 0;
            end else begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req0_x = 4'($urandom); bus.req0_y = 4'($urandom); bus.req0_sub = 1'($urandom);
            end
            if (bus.req1_valid && !acc1) begin
                if ($urandom_range(0, 7) == 0) bus.req1_valid = 0;
            end else begin
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req1_x = 4'($urandom); bus.req1_y = 4'($urandom); bus.req1_sub = 1'($urandom);
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
        end
        drain();
        @(negedge clk);
        chk("drain_no_pending", pend_valid, 0);
        chk("drain_rsp_valid", bus.rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
